// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator wrapper: write-word width and
// run-state encoding used by the write buffer.
package acc_pkg;

  localparam int ACC_DATA_W = 21;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    WAIT_EMPTY = 2'd2,
    FLUSHED    = 2'd3
  } run_state_t;

endpackage

// File: rtl/acc_wr_buffer_if.sv
// Bus bundle for acc_wr_buffer: upstream write port, sink handshake and
// run-status outputs. The master side is whoever drives the buffer's inputs.
interface acc_wr_buffer_if
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int CNT_W  = 8
);

  logic              start;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              acc_done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [CNT_W-1:0]  word_cnt;
  logic              flushed;

  modport master (
    output start, wr_req, wr_data, acc_done, out_ready,
    input  out_valid, out_data, full, empty, overflow, word_cnt, flushed
  );

  modport slave (
    input  start, wr_req, wr_data, acc_done, out_ready,
    output out_valid, out_data, full, empty, overflow, word_cnt, flushed
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit 0..DEPTH occupancy counter. Push/pop are
// qualified here; a pop never sees a word pushed in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              push_ok
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [OCC_W-1:0]  occ_r;
  logic              pop_ok_s;

  assign full     = (occ_r == OCC_W'(DEPTH));
  assign empty    = (occ_r == {OCC_W{1'b0}});
  assign pop_ok_s = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push_req && (!full || pop_ok_s);
  assign pop_data = mem_r[rd_ptr_r];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok, pop_ok_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/acc_wr_buffer.sv
// Write buffer between the accelerator and the result sink: FIFO plus drop
// detection, accepted-word counting and end-of-run (flushed) tracking.
module acc_wr_buffer
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  acc_wr_buffer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             push_ok_s;
  logic             drop_s;
  logic             overflow_r;
  logic [CNT_W-1:0] word_cnt_r;
  logic             flushed_r;
  run_state_t       state_r;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_req  (bus.wr_req),
    .push_data (bus.wr_data),
    .pop_req   (bus.out_ready),
    .pop_data  (bus.out_data),
    .full      (bus.full),
    .empty     (bus.empty),
    .push_ok   (push_ok_s)
  );

  assign drop_s        = bus.wr_req && !push_ok_s;
  assign bus.out_valid = !bus.empty;
  assign bus.overflow  = overflow_r;
  assign bus.word_cnt  = word_cnt_r;
  assign bus.flushed   = flushed_r;

  // Sticky overflow; a drop in the start cycle still counts for the new run.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (bus.start) begin
      overflow_r <= drop_s;
    end else begin
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Saturating accepted-word counter; a push with start counts after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.start) begin
      word_cnt_r <= push_ok_s ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (push_ok_s && (word_cnt_r != CNT_MAX)) begin
      word_cnt_r <= word_cnt_r + CNT_W'(1);
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  // Run FSM with registered flushed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      flushed_r <= 1'b0;
    end else if (bus.start) begin
      state_r   <= RUN;
      flushed_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= IDLE;
          flushed_r <= 1'b0;
        end
        RUN: begin
          if (bus.acc_done) begin
            state_r <= WAIT_EMPTY;
          end
          flushed_r <= 1'b0;
        end
        WAIT_EMPTY: begin
          if (bus.empty && !push_ok_s) begin
            state_r   <= FLUSHED;
            flushed_r <= 1'b1;
          end
        end
        FLUSHED: begin
          state_r   <= FLUSHED;
          flushed_r <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          flushed_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/acc_wr_buffer.md
Name: acc_wr_buffer

Overview:
- Downstream stage of the accelerator wrapper. Captures every wr_req/wr_data beat into a small FIFO and drains it to the result sink over a valid/ready handshake.
- Absorbs bursts, because the accelerator's write port has no backpressure.
- Tracks the end of a run: the accelerator's done pulse is latched, and flushed asserts once every accepted word has been handed off.

Parameters:
- DATA_W, 21, width of wr_data / out_data words
- DEPTH, 8, FIFO entries; power of two, minimum 2
- CNT_W, 8, width of the accepted-word counter

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  run-start pulse, same signal that starts the accelerator; clears run status
- wr_req  input  1  upstream write strobe; one word per cycle it is high
- wr_data  input  DATA_W  upstream write word, valid when wr_req=1
- acc_done  input  1  upstream done pulse or level; end of run
- out_valid  output  1  head word available
- out_ready  input  1  sink accepts head word
- out_data  output  DATA_W  head-of-FIFO word
- full  output  1  FIFO holds DEPTH words
- empty  output  1  FIFO holds 0 words
- overflow  output  1  sticky: at least one wr_req beat was dropped
- word_cnt  output  CNT_W  words accepted since last start/reset, saturating
- flushed  output  1  run complete: acc_done seen and FIFO drained

Behaviour:
- Reset (rst=1 at a clock edge): pointers and occupancy cleared, run FSM to IDLE.
  - Outputs: out_valid=0, empty=1, full=0, overflow=0, word_cnt=0, flushed=0.
  - FIFO storage contents are don't-care.
  - Reset mid-drain discards all stored words; the sink must not see a further out_valid until a new push.
  - rst has priority over start and every other input.
- Push: accepted when wr_req=1 and (occupancy<DEPTH, or a pop occurs in the same cycle).
  - Accepted word written at wr_ptr; wr_ptr increments modulo DEPTH.
  - word_cnt increments, saturating at 2^CNT_W-1.
- Drop: wr_req=1 while full and no pop in that cycle.
  - Word is discarded, overflow set to 1 on the next edge, word_cnt unchanged, pointers unchanged.
- Pop: occurs when out_valid=1 and out_ready=1. rd_ptr increments modulo DEPTH.
- out_valid = !empty. out_data = storage[rd_ptr], a combinational read of registered storage.
  - out_data is don't-care while empty.
- Latency: a word pushed at edge N is presented with out_valid=1 after edge N; a sink with out_ready=1 pops it at edge N+1.
- Order: strict FIFO; no word is duplicated or reordered.
- Simultaneous push and pop:
  - Occupancy unchanged.
  - Legal when full (the pop frees the slot).
  - Legal when empty only if not empty at the edge; no fall-through bypass.
- Occupancy register runs 0..DEPTH. full = (occupancy==DEPTH), empty = (occupancy==0). Both are registered-state derived, with no glitch paths from inputs.
- Run FSM:
  - IDLE: start=1 → RUN. Clears overflow, word_cnt and flushed; does not clear FIFO contents.
  - RUN: acc_done=1 → WAIT_EMPTY.
  - WAIT_EMPTY: empty at the edge with no push in that cycle → FLUSHED.
  - FLUSHED: flushed=1 (level). start=1 → RUN, with the same clears as from IDLE.
- start in RUN or WAIT_EMPTY restarts: clears overflow, word_cnt and flushed, state → RUN.
- Pushes are accepted in every state, including after acc_done. A push in WAIT_EMPTY delays the FLUSHED transition.
- start and wr_req in the same cycle: the push is counted after the clear, so word_cnt=1.
- acc_done while IDLE is ignored.

Decomposition:
- Shared package acc_pkg holds:
  - ACC_DATA_W = 21, the accelerator write-word width shared with the wrapper.
  - Run-state encoding: IDLE=2'd0, RUN=2'd1, WAIT_EMPTY=2'd2, FLUSHED=2'd3.
- One sub-module, sync_fifo (DATA_W, DEPTH): storage, pointers, occupancy, full/empty, push/pop qualification.
- The top-level acc_wr_buffer adds the drop/overflow logic, word_cnt and the run FSM.

Test Plan:
- Reset hold: rst=1 for 3 cycles with wr_req=1, wr_data=21'h1ABCD → after release, empty=1, out_valid=0, word_cnt=0, overflow=0, flushed=0.
- Basic pass-through: start pulse, push 21'h00001, 21'h00002, 21'h00003 on consecutive cycles with out_ready=1 → sink receives 1, 2, 3 in order, each one cycle after its push; word_cnt=3; empty=1 at the end.
- Fill and overflow: out_ready=0, push 10 words 21'h10..21'h19 → full=1 after the 8th, overflow=1 one cycle after the 9th, word_cnt=8. Then out_ready=1 drains exactly 21'h10..21'h17.
- Push/pop when full: fill 8 words, then wr_req=1 with out_ready=1 for 4 cycles → no drop, overflow stays 0, full stays 1, word_cnt=12, output order preserved.
- Flush tracking: start, push 5 words, pulse acc_done with out_ready=0 → flushed=0. Set out_ready=1: flushed=1 the cycle after the 5th pop. A second start clears flushed and word_cnt to 0.
- Reset mid-drain: 4 words queued, rst=1 for 1 cycle → out_valid=0, word_cnt=0, FSM in IDLE. The next push of 21'h0F0F0 appears alone at out_data.
